seed_rng: RTL and testbench
===========================

# seed_rng

Seeded 12-bit pseudo-random number generator sitting directly downstream of the seed generator. It loads the latched 12-bit seed into a maximal-length Fibonacci LFSR, then serves per-request random values uniformly in a caller-supplied range [0, limit) via bounded rejection sampling. Game logic issues `req` and consumes `rnd` on the `rnd_valid` pulse.

## Interface
- `MAX_TRIES`, default 16: LFSR steps allowed per request before fallback (1..16).
- `ZERO_SUB`, default 12'hACE: state loaded when `seed` is 0, avoiding LFSR lock-up.

- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `seed`  in  12  seed value, sampled on `load`.
- `load`  in  1  one-cycle strobe: load `seed` into the LFSR.
- `req`  in  1  request strobe, sampled in IDLE only.
- `limit`  in  12  exclusive upper bound, sampled with `req`; 0 means 4096 (full range).
- `rnd`  out  12  accepted random value, held until next accept.
- `rnd_valid`  out  1  one-cycle pulse: `rnd` updated.
- `busy`  out  1  high while a request is in progress (state GEN).

## Operation
- LFSR: taps 12,6,4,1. `fb = s[11]^s[5]^s[3]^s[0]`; `next = {s[10:0], fb}`. Period 4095; all-zero state unreachable.
- LFSR advances only in GEN; it is frozen in IDLE.
- Load: `s <= (seed==0) ? ZERO_SUB : seed`. Accepted in any state and has priority over everything else. In GEN it aborts the request: return to IDLE, no `rnd_valid`, `rnd` unchanged.
- States:
  - IDLE: on `req && !load`, capture `limit_q = limit`, `mask_q`, `tries = 0`, go to GEN.
  - GEN: each cycle `s <= next`, `cand = next & mask_q`.
    - If `cand < limit_q` (limit_q = 0 treated as 4096, always accept): `rnd <= cand`, pulse `rnd_valid`, go to IDLE.
    - Else if `tries == MAX_TRIES-1`: `rnd <= cand - limit_q`, which is always < limit, then pulse and go to IDLE.
    - Else `tries++`.
- Mask: smallest `2^k-1 >= limit-1`, computed by OR-smearing `limit-1` (13-bit arithmetic; limit 0 gives 12'hFFF). Examples: limit 1 gives mask 0; limit 5 gives 7; limit 4096 (0) gives FFF.
- `req` while busy is ignored, not queued.
- Reset values: `s = 12'h001`, `rnd = 0`, `rnd_valid = 0`, `busy = 0`, state IDLE, `tries = 0`, `limit_q = 0`, `mask_q = 0`.

## Timing
- `req` sampled at edge E0. GEN steps at E1, E2, and so on.
- Accept on step n: `rnd`/`rnd_valid` valid after edge En; `busy` is low in the same cycle.
- Best-case latency is 1 GEN cycle, so `rnd_valid` is high in the cycle after the `req` cycle. Worst case is `MAX_TRIES` cycles.
- Back-to-back: a new `req` may be asserted in the cycle `rnd_valid` is high (state is IDLE).
- `busy` = (state == GEN), registered.
- Reset asserted mid-GEN: immediate return to reset values; no pulse.
- `load` and `req` in the same IDLE cycle: load only; `req` is dropped.

## Test plan
- Reset, then 4 requests with `limit=0` spaced 3 cycles apart: `rnd` = 0x003, 0x007, 0x00F, 0x01E. Each `rnd_valid` arrives 1 cycle after its `req` cycle, and `busy` is high for exactly 1 cycle each.
- Reset, then `req` with `limit=3` (mask 3): candidates 3, 3, 3 are rejected and 0x01E&3=2 is accepted. Required: `rnd=2`, `rnd_valid` after the 4th GEN edge, `busy` high for 4 cycles.
- `load` with `seed=0`, then `req` with `limit=0`: LFSR = 0xACE, so `rnd=0x59C`. Also `load` with `seed=0x123`, then `req` with `limit=0`: `rnd=0x246`.
- Reset, then `req` with `limit=1`: `rnd=0` after 1 GEN cycle. A following `req` with `limit=0` returns 0x007, which confirms the LFSR advanced.
- Abort: `req` with `limit=3`, then `load` with `seed=0x001` on the 2nd GEN cycle. Required: no `rnd_valid`, `busy` falls, `rnd` unchanged. A following `req` with `limit=0` gives 0x003.
- Fallback with `MAX_TRIES=2`, reset, `req` with `limit=3`: two rejects, then `rnd = 3-3 = 0` after 2 cycles. `req` pulsed while busy produces no extra `rnd_valid`.

Source files
------------

// File: rtl/seed_rng.sv
// Seeded 12-bit Fibonacci LFSR that serves random values in [0, limit)
// using bounded rejection sampling with a subtract-based fallback.
module seed_rng #(
    parameter int          MAX_TRIES = 16,
    parameter logic [11:0] ZERO_SUB  = 12'hACE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] seed,
    input  logic        load,
    input  logic        req,
    input  logic [11:0] limit,
    output logic [11:0] rnd,
    output logic        rnd_valid,
    output logic        busy
);

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state;
    logic [11:0] s;
    logic [11:0] limit_q;
    logic [11:0] mask_q;
    logic [3:0]  tries;

    logic [11:0] lfsr_next;
    logic [11:0] cand;
    logic [12:0] limit_ext;
    logic [12:0] limit_m1;
    logic [11:0] mask_new;
    logic        accept;
    logic        last_try;

    // limit_q of zero stands for the full 4096 range, so compare in 13 bits
    always_comb begin
        lfsr_next = {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
        cand      = lfsr_next & mask_q;
        limit_ext = (limit_q == 12'd0) ? 13'h1000 : {1'b0, limit_q};
        accept    = ({1'b0, cand} < limit_ext);
        last_try  = (tries == 4'(MAX_TRIES - 1));
        limit_m1  = {1'b0, limit} - 13'd1;
        mask_new  = limit_m1[11:0];
        mask_new  = mask_new | (mask_new >> 1);
        mask_new  = mask_new | (mask_new >> 2);
        mask_new  = mask_new | (mask_new >> 4);
        mask_new  = mask_new | (mask_new >> 8);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            s         <= 12'h001;
            rnd       <= 12'd0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
            tries     <= 4'd0;
            limit_q   <= 12'd0;
            mask_q    <= 12'd0;
        end else begin
            rnd_valid <= 1'b0;
            if (load) begin
                // a load always wins and silently abandons any pending request
                s     <= (seed == 12'd0) ? ZERO_SUB : seed;
                state <= IDLE;
                busy  <= 1'b0;
                tries <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            limit_q <= limit;
                            mask_q  <= mask_new;
                            tries   <= 4'd0;
                            state   <= GEN;
                            busy    <= 1'b1;
                        end
                    end
                    GEN: begin
                        s <= lfsr_next;
                        if (accept) begin
                            rnd       <= cand;
                            rnd_valid <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else if (last_try) begin
                            // cand < 2*limit here, so the difference stays in range
                            rnd       <= cand - limit_q;
                            rnd_valid <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            tries <= tries + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seed_rng.sv
// Directed bench for seed_rng: expected values queued on request, compared on rnd_valid.
module tb_seed_rng;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] seed;
    logic [11:0] limit;
    logic        loadA, reqA, loadB, reqB;
    logic [11:0] rndA, rndB;
    logic        validA, validB, busyA, busyB;

    int          testCnt = 0;
    int          failCnt = 0;
    logic [11:0] expQ[$];
    int          latQ[$];
    logic [11:0] mState;

    always #5 clk = ~clk;

    seed_rng dutA (
        .clk(clk), .resetn(resetn), .seed(seed), .load(loadA), .req(reqA),
        .limit(limit), .rnd(rndA), .rnd_valid(validA), .busy(busyA)
    );

    seed_rng #(.MAX_TRIES(2)) dutB (
        .clk(clk), .resetn(resetn), .seed(seed), .load(loadB), .req(reqB),
        .limit(limit), .rnd(rndB), .rnd_valid(validB), .busy(busyB)
    );

    function automatic logic curBusy(input bit sel);
        return sel ? busyB : busyA;
    endfunction

    function automatic logic curValid(input bit sel);
        return sel ? validB : validA;
    endfunction

    function automatic logic [11:0] curRnd(input bit sel);
        return sel ? rndB : rndA;
    endfunction

    task automatic driveReq(input bit sel, input logic v);
        if (sel) reqB = v;
        else     reqA = v;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic loadSeed(input logic [11:0] v);
        @(negedge clk);
        loadA = 1'b1;
        seed  = v;
        @(negedge clk);
        loadA = 1'b0;
    endtask

    // Reference behaviour built from the LFSR definition, used for extra limits
    task automatic modelReq(input int lim, input int maxTries, output int val, output int lat);
        int lim13;
        int m;
        lim13 = (lim == 0) ? 4096 : lim;
        m = 0;
        while (m < lim13 - 1) m = m * 2 + 1;
        val = 0;
        lat = 0;
        for (int n = 1; n <= maxTries; n++) begin
            mState = {mState[10:0], mState[11] ^ mState[5] ^ mState[3] ^ mState[0]};
            if ((int'(mState) & m) < lim13) begin
                val = int'(mState) & m;
                lat = n;
                break;
            end
            if (n == maxTries) begin
                val = (int'(mState) & m) - lim13;
                lat = n;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit sel, input logic [11:0] lim,
                                 input logic [11:0] expVal, input int expLat, input int extraAt);
        int          lat = -1;
        int          busyCnt = 0;
        int          extra = 0;
        logic [11:0] got = 12'hxxx;
        expQ.push_back(expVal);
        latQ.push_back(expLat);
        @(negedge clk);
        limit = lim;
        driveReq(sel, 1'b1);
        @(negedge clk);
        driveReq(sel, 1'b0);
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k > 0) begin
                @(negedge clk);
                driveReq(sel, k == extraAt);
            end
            if (curBusy(sel)) busyCnt++;
            if (curValid(sel)) begin
                lat = k;
                got = curRnd(sel);
            end
        end
        driveReq(sel, 1'b0);
        repeat (4) begin
            @(negedge clk);
            if (curValid(sel)) extra++;
        end
        checkOutput({tag, "_rnd"}, int'(got), int'(expQ.pop_front()));
        checkOutput({tag, "_latency"}, lat, latQ.pop_front());
        checkOutput({tag, "_busyCycles"}, busyCnt, expLat);
        checkOutput({tag, "_extraPulses"}, extra, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int mVal;
        int mLat;
        int lims[4] = '{5, 100, 2048, 7};

        resetn = 1'b0;
        seed   = 12'd0;
        limit  = 12'd0;
        loadA  = 1'b0;
        reqA   = 1'b0;
        loadB  = 1'b0;
        reqB   = 1'b0;

        resetDut();
        checkOutput("resetRnd", int'(rndA), 0);
        checkOutput("resetValid", int'(validA), 0);
        checkOutput("resetBusy", int'(busyA), 0);

        applyStimulus("full1", 1'b0, 12'd0, 12'h003, 1, 0);
        applyStimulus("full2", 1'b0, 12'd0, 12'h007, 1, 0);
        applyStimulus("full3", 1'b0, 12'd0, 12'h00F, 1, 0);
        applyStimulus("full4", 1'b0, 12'd0, 12'h01E, 1, 0);

        resetDut();
        applyStimulus("lim3", 1'b0, 12'd3, 12'h002, 4, 0);

        loadSeed(12'h000);
        applyStimulus("seedZero", 1'b0, 12'd0, 12'h59C, 1, 0);
        loadSeed(12'h123);
        applyStimulus("seed123", 1'b0, 12'd0, 12'h246, 1, 0);

        resetDut();
        applyStimulus("lim1", 1'b0, 12'd1, 12'h000, 1, 0);
        applyStimulus("lim1Next", 1'b0, 12'd0, 12'h007, 1, 0);

        // Abort an in-flight request with a load
        resetDut();
        applyStimulus("preAbort", 1'b0, 12'd0, 12'h003, 1, 0);
        @(negedge clk);
        limit = 12'd3;
        reqA  = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        checkOutput("abortBusyStart", int'(busyA), 1);
        @(negedge clk);
        checkOutput("abortNoEarlyValid", int'(validA), 0);
        loadA = 1'b1;
        seed  = 12'h001;
        @(negedge clk);
        loadA = 1'b0;
        checkOutput("abortBusy", int'(busyA), 0);
        checkOutput("abortValid", int'(validA), 0);
        checkOutput("abortRnd", int'(rndA), 12'h003);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (validA) pulses++;
        end
        checkOutput("abortPulses", pulses, 0);
        applyStimulus("postAbort", 1'b0, 12'd0, 12'h003, 1, 0);

        // load and req in the same cycle: req is dropped
        @(negedge clk);
        loadA = 1'b1;
        seed  = 12'h123;
        reqA  = 1'b1;
        limit = 12'd0;
        @(negedge clk);
        loadA = 1'b0;
        reqA  = 1'b0;
        checkOutput("loadReqBusy", int'(busyA), 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (validA || busyA) pulses++;
        end
        checkOutput("loadReqActivity", pulses, 0);
        applyStimulus("loadReqNext", 1'b0, 12'd0, 12'h246, 1, 0);

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        limit = 12'd3;
        reqA  = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midResetBusy", int'(busyA), 0);
        checkOutput("midResetRnd", int'(rndA), 0);
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("midResetValid", int'(validA), 0);

        // Other limits against the reference model
        resetDut();
        mState = 12'h001;
        foreach (lims[i]) begin
            modelReq(lims[i], 16, mVal, mLat);
            applyStimulus($sformatf("model%0d", lims[i]), 1'b0, 12'(lims[i]), 12'(mVal), mLat, 0);
        end

        // Fallback path with two tries, plus a req while busy
        resetDut();
        checkOutput("fallbackResetBusy", int'(busyB), 0);
        applyStimulus("fallback", 1'b1, 12'd3, 12'h000, 2, 1);
        checkOutput("fallbackIdle", int'(busyB), 0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
